// File: rtl/sseg_pkg.sv
// Shared types, constants and the hex-to-segment table for the 7-segment scan driver.
// All segment vectors are [0:6] = a..g, in logical polarity (1 = segment lit).
package sseg_pkg;

  localparam logic [0:6] SEG_OFF = 7'b0000000;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Hex nibble to logical abcdefg; seg[0] is segment a.
  function automatic logic [0:6] hex_to_seg(input logic [3:0] nib);
    logic [0:6] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      4'hF:    s = 7'b1000111;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// Bus between the datapath (master) and the display scan driver (slave).
// Display outputs are at pin polarity; request inputs are logical (1 = lit / dark / enable).
interface sseg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    load;
  logic                    lz_en;
  logic [0:6]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output value, dp_in, blank, load, lz_en,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  value, dp_in, blank, load, lz_en,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational nibble to logical abcdefg decoder.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  // Table lookup, logical polarity.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver.
// Each digit slot is REFRESH_DIV cycles: GUARD_CYCLES with all anodes off, then SHOW.
// The displayed value is double-buffered: load writes the shadow copy, and the shadow
// moves to the active copy only at a slot boundary, so a digit never changes mid-show.
// Pins are registered and therefore trail the FSM/index state by one cycle.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input logic            clk,
  input logic            reset,
  sseg_scan_mux_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:6]            SEG_PIN_OFF = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_PIN_OFF  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  scan_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [VAL_W-1:0]      shd_value_q, shd_value_d;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0] shd_blank_q, shd_blank_d;
  logic [VAL_W-1:0]      act_value_q, act_value_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;

  logic [0:6]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  slot_end_s;
  logic                  frame_end_s;
  logic [3:0]            nib_s;
  logic [0:6]            dec_seg_s;
  logic [NUM_DIGITS-1:0] lz_mask_s;
  logic                  zero_run_s;
  logic                  dark_s;
  logic [0:6]            seg_l_s;
  logic                  dp_l_s;
  logic [NUM_DIGITS-1:0] an_l_s;

  sseg_hex_decode u_dec (
    .nibble (nib_s),
    .seg    (dec_seg_s)
  );

  // Slot counter, digit index and GUARD/SHOW next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    slot_end_s  = 1'b0;
    frame_end_s = 1'b0;
    if (cnt_q == CNT_LAST) begin
      slot_end_s = 1'b1;
      cnt_d      = '0;
      state_d    = ST_GUARD;
      if (idx_q == IDX_LAST) begin
        idx_d       = '0;
        frame_end_s = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      case (state_q)
        ST_GUARD: begin
          if (cnt_d >= CNT_SHOW) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_GUARD;
          end
        end
        ST_SHOW:  state_d = ST_SHOW;
        default:  state_d = ST_GUARD;
      endcase
    end
  end

  // Shadow capture on load; shadow-to-active transfer at each slot boundary (GUARD start).
  always_comb begin
    shd_value_d = shd_value_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (bus.load) begin
      shd_value_d = bus.value;
      shd_dp_d    = bus.dp_in;
      shd_blank_d = bus.blank;
    end else begin
      shd_value_d = shd_value_q;
    end
    if (slot_end_s) begin
      act_value_d = shd_value_q;
      act_dp_d    = shd_dp_q;
      act_blank_d = shd_blank_q;
    end else begin
      act_value_d = act_value_q;
    end
  end

  // Leading-zero mask: digit k>0 is suppressible when nibbles k..top are all zero.
  always_comb begin
    lz_mask_s  = '0;
    zero_run_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run_s   = zero_run_s & (act_value_q[4*k +: 4] == 4'h0);
      lz_mask_s[k] = zero_run_s & (k != 0);
    end
  end

  // Current digit content, then pin polarity; frame_tick follows the index wrap.
  always_comb begin
    nib_s        = act_value_q[{idx_q, 2'b00} +: 4];
    dark_s       = act_blank_q[idx_q] | (bus.lz_en & lz_mask_s[idx_q]);
    seg_l_s      = SEG_OFF;
    dp_l_s       = 1'b0;
    an_l_s       = '0;
    frame_tick_d = frame_end_s;
    if (state_q == ST_SHOW) begin
      an_l_s = NUM_DIGITS'(1) << idx_q;
      if (dark_s) begin
        seg_l_s = SEG_OFF;
        dp_l_s  = 1'b0;
      end else begin
        seg_l_s = dec_seg_s;
        dp_l_s  = act_dp_q[idx_q];
      end
    end else begin
      an_l_s = '0;
    end
    if (ACTIVE_LOW != 0) begin
      seg_d = ~seg_l_s;
      dp_d  = ~dp_l_s;
      an_d  = ~an_l_s;
    end else begin
      seg_d = seg_l_s;
      dp_d  = dp_l_s;
      an_d  = an_l_s;
    end
  end

  // State, buffers and registered pins with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      shd_value_q  <= '0;
      shd_dp_q     <= '0;
      shd_blank_q  <= '0;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      seg_q        <= SEG_PIN_OFF;
      dp_q         <= DP_PIN_OFF;
      an_q         <= AN_PIN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shd_value_q  <= shd_value_d;
      shd_dp_q     <= shd_dp_d;
      shd_blank_q  <= shd_blank_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
